// File: rtl/quad_encoder_emu.sv
// Quadrature encoder emulator: emits a commanded number of A/B quarter-phase
// edges at a fixed clock period, tracking a signed position count.
module quad_encoder_emu #(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 16,
  parameter int POS_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              enc_a,
  output logic              enc_b,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic [1:0]         phase_q, phase_d;   // {A,B}
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               done_q, done_d;

  logic               emit;
  logic               emit_dir;
  logic [DIV_W-1:0]   per_eff;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    period_d = period_q;
    div_d    = div_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    emit     = 1'b0;
    emit_dir = dir_q;
    per_eff  = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          period_d = per_eff;
          emit_dir = cmd_dir;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (done_q && per_eff == DIV_W'(1)) begin
            // Chained at period 1: the first edge lands on the accept edge itself
            emit  = 1'b1;
            rem_d = cmd_steps - STEP_W'(1);
            div_d = per_eff;
            if (cmd_steps == STEP_W'(1)) done_d  = 1'b1;
            else                         state_d = RUN;
          end else begin
            state_d = RUN;
            rem_d   = cmd_steps;
            // Accepting in the done cycle absorbs that cycle into the first period
            div_d   = done_q ? per_eff - DIV_W'(1) : per_eff;
          end
        end
      end
      RUN: begin
        if (div_q == DIV_W'(1) && rem_q == STEP_W'(1)) begin
          emit    = 1'b1;
          rem_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = IDLE;
        end else if (div_q == DIV_W'(1)) begin
          emit  = 1'b1;
          div_d = period_q;
          rem_d = rem_q - STEP_W'(1);
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      // Gray step: forward 00->10->11->01, reverse 00->01->11->10
      phase_d = emit_dir ? {~phase_q[0], phase_q[1]} : {phase_q[0], ~phase_q[1]};
      pos_d   = emit_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      period_q <= DIV_W'(1);
      div_q    <= DIV_W'(1);
      rem_q    <= '0;
      phase_q  <= 2'b00;
      pos_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      done_q   <= done_d;
    end
  end

  assign enc_a     = phase_q[1];
  assign enc_b     = phase_q[0];
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_emu.sv
// Scoreboard bench for quad_encoder_emu: stimulus pushes expected edge/done
// events, a monitor pops and compares them whenever A/B changes or done pulses.
module tb_quad_encoder_emu;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_dir, abort;
  logic [15:0] cmd_steps, cmd_period;
  logic        enc_a, enc_b, busy, done;
  logic [31:0] position;

  logic        v2, r2, a2, b2, busy2, done2;
  logic [7:0]  pos2;

  quad_encoder_emu dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done), .position(position)
  );

  quad_encoder_emu #(.POS_W(8)) dut8 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(v2), .cmd_ready(r2), .cmd_dir(1'b1),
    .cmd_steps(16'd130), .cmd_period(16'd1), .abort(1'b0),
    .enc_a(a2), .enc_b(b2), .busy(busy2), .done(done2), .position(pos2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  ab;
    logic [31:0] pos;
    logic        dn;
  } ev_t;

  ev_t         q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [1:0]  m_ab = 2'b00;
  logic [31:0] m_pos = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    logic [1:0] prev_ab, ab;
    ev_t e;
    prev_ab = 2'b00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      ab = {enc_a, enc_b};
      if (mon_en && (ab != prev_ab || done)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event ab=%b done=%b pos=%0h (cyc %0d)", ab, done, position, cyc);
        end else begin
          e = q.pop_front();
          check("ev_cycle", 64'(cyc), 64'(e.cyc));
          check("ev_ab",    64'(ab),  64'(e.ab));
          check("ev_pos",   64'(position), 64'(e.pos));
          check("ev_done",  64'(done), 64'(e.dn));
        end
      end
      prev_ab = ab;
    end
  end

  // Model: events i=1..n_emit at base + i*p; done only on the n-th edge
  task automatic push_cmd(input bit dir, input int n, input int p, input int base, input int n_emit);
    ev_t e;
    if (n == 0) begin
      e.cyc = base; e.ab = m_ab; e.pos = m_pos; e.dn = 1'b1;
      q.push_back(e);
    end
    for (int i = 1; i <= n_emit; i++) begin
      m_ab  = dir ? {~m_ab[0], m_ab[1]} : {m_ab[0], ~m_ab[1]};
      m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
      e.cyc = base + i * p; e.ab = m_ab; e.pos = m_pos; e.dn = (i == n);
      q.push_back(e);
    end
  endtask

  // Raise valid at a falling edge while ready; returns the accepting edge's cycle
  task automatic issue(input bit dir, input int steps, input int per, output int acc);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 500) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      $display("FAIL issue_timeout ready=%b", cmd_ready);
      $fatal(1, "cmd_ready never rose");
    end
    cmd_dir = dir; cmd_steps = 16'(steps); cmd_period = 16'(per);
    cmd_valid = 1'b1;
    acc = cyc + 1;
  endtask

  task automatic release_cmd();
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #2; end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin @(posedge clk); #2; guard++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ab",    64'({enc_a, enc_b}), 64'd0);
    check("rst_pos",   64'(position), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    m_ab = 2'b00; m_pos = '0;
    @(posedge clk); #2;
    mon_en = 1'b1;
  endtask

  initial begin : stim
    int acc, last;
    bit saw_wrap;
    int done2_cnt;
    logic [7:0] prev2;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    cmd_period = '0; abort = 1'b0; v2 = 1'b0;
    #1 rst_n = 1'b0;

    // Forward N=4 P=3: 10,11,01,00 at +3,+6,+9,+12
    do_reset();
    issue(1'b1, 4, 3, acc);
    push_cmd(1'b1, 4, 3, acc, 4);
    release_cmd();
    at_cyc(acc);      check("fwd_busy_first", 64'(busy), 64'd1);
    at_cyc(acc + 11); check("fwd_busy_last",  64'(busy), 64'd1);
    at_cyc(acc + 12); check("fwd_busy_off",   64'(busy), 64'd0);
    check("fwd_ready", 64'(cmd_ready), 64'd1);
    check("fwd_pos", 64'(position), 64'd4);
    drain();
    repeat (3) @(posedge clk);

    // Reverse N=5 P=1 from 00: 01,11,10,00,01, position -5
    do_reset();
    issue(1'b0, 5, 1, acc);
    push_cmd(1'b0, 5, 1, acc, 5);
    release_cmd();
    drain();
    check("rev_pos", 64'(position), 64'h0000_0000_FFFF_FFFB);
    check("rev_ab",  64'({enc_a, enc_b}), 64'b01);
    repeat (3) @(posedge clk);

    // Period 0 behaves as period 1
    issue(1'b1, 2, 0, acc);
    push_cmd(1'b1, 2, 1, acc, 2);
    release_cmd();
    drain();
    repeat (3) @(posedge clk);
    issue(1'b1, 2, 1, acc);
    push_cmd(1'b1, 2, 1, acc, 2);
    release_cmd();
    drain();
    repeat (3) @(posedge clk);

    // Zero-step command: done one cycle after accept, ready stays high
    issue(1'b1, 0, 5, acc);
    push_cmd(1'b1, 0, 5, acc, 0);
    release_cmd();
    at_cyc(acc);
    check("zero_ready", 64'(cmd_ready), 64'd1);
    check("zero_busy",  64'(busy), 64'd0);
    drain();
    repeat (3) @(posedge clk);

    // Abort in IDLE is ignored
    abort = 1'b1; repeat (2) @(posedge clk); #2; abort = 1'b0;
    check("idle_abort_ready", 64'(cmd_ready), 64'd1);

    // Abort at accept+7 during N=10 P=2: three edges, no done
    do_reset();
    issue(1'b1, 10, 2, acc);
    push_cmd(1'b1, 10, 2, acc, 3);
    release_cmd();
    at_cyc(acc + 6); abort = 1'b1;
    at_cyc(acc + 7); abort = 1'b0;
    check("abort_ready", 64'(cmd_ready), 64'd1);
    check("abort_busy",  64'(busy), 64'd0);
    repeat (8) @(posedge clk); #2;
    drain();
    check("abort_pos", 64'(position), 64'd3);

    // Back-to-back: forward 2 @P4, reverse 2 @P4 accepted in the done cycle
    do_reset();
    issue(1'b1, 2, 4, acc);
    push_cmd(1'b1, 2, 4, acc, 2);
    release_cmd();
    last = acc + 8;
    at_cyc(last);
    check("b2b_done_cycle", 64'(done), 64'd1);
    issue(1'b0, 2, 4, acc);
    check("b2b_acc", 64'(acc), 64'(last + 1));
    push_cmd(1'b0, 2, 4, last, 2);
    release_cmd();
    drain();
    check("b2b_pos", 64'(position), 64'd0);
    check("b2b_ab",  64'({enc_a, enc_b}), 64'b00);
    repeat (3) @(posedge clk);

    // 8-bit position wrap on the second instance: 130 forward steps
    saw_wrap = 1'b0; done2_cnt = 0; prev2 = pos2;
    @(negedge clk); v2 = 1'b1;
    @(posedge clk); #2; v2 = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (prev2 == 8'h7F && pos2 == 8'h80) saw_wrap = 1'b1;
      if (done2) done2_cnt++;
      prev2 = pos2;
    end
    check("wrap_seen",  64'(saw_wrap), 64'd1);
    check("wrap_pos",   64'(pos2), 64'h82);
    check("wrap_done",  64'(done2_cnt), 64'd1);

    // Asynchronous reset mid-RUN
    mon_en = 1'b0;
    issue(1'b1, 20, 2, acc);
    release_cmd();
    at_cyc(acc + 9);
    check("mid_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ab",    64'({enc_a, enc_b}), 64'd0);
    check("arst_pos",   64'(position), 64'd0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_done",  64'(done), 64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk); #2;
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_emu.md
# quad_encoder_emu

Quadrature encoder emulator: generates the two-phase A/B signals a rotary encoder produces, stepping a commanded number of quarter-phase edges at a commanded rate and direction. It is the transmitting end of the encoder interface that the Nios system's encoder input peripheral decodes. It drives two GPIO pins, which are looped back to the encoder input for closed-loop bring-up of the PWM/encoder motor path without a physical motor. Commands arrive over a valid/ready handshake from a PIO or a bench driver.

## Interface
Parameters:
- DIV_W, 16: width of the step-period divider.
- STEP_W, 16: width of the step-count field.
- POS_W, 32: width of the signed position counter.

Ports:
- clk_clk  in  1  system clock (50 MHz); all logic on rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high exactly when state is IDLE.
- cmd_dir  in  1  direction: 1 = forward (A leads B), 0 = reverse.
- cmd_steps  in  STEP_W  number of quarter-phase edges to emit.
- cmd_period  in  DIV_W  clock cycles between edges; 0 is treated as 1.
- abort  in  1  synchronous abort of the command in progress.
- enc_a  out  1  encoder phase A, registered.
- enc_b  out  1  encoder phase B, registered.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a command completes normally.
- position  out  POS_W  signed count of emitted edges: +1 forward, -1 reverse.

## Operation
- States: IDLE and RUN.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready, latch dir, steps and period (with 0 mapped to 1).
  - If steps == 0: pulse done next cycle, stay IDLE, emit no edges.
  - Otherwise: go to RUN, load the divider with period, set remaining = steps.
- RUN:
  - The divider decrements each cycle.
  - When it would reach 0, emit one edge, reload with period, and decrement remaining.
  - If that was the last edge: go to IDLE and assert done in the same cycle the last edge appears on enc_a/enc_b.
- Phase sequence {A,B}:
  - Forward: 00→10→11→01→00.
  - Reverse: 00→01→11→10→00.
  - Exactly one of A/B toggles per edge; no glitches.
  - Phase persists across commands and direction changes; the sequence continues from the current phase.
- Position:
  - Updated in the same cycle as each edge.
  - Two's-complement wrap modulo 2^POS_W in both directions; no saturation.
- Abort:
  - Abort in RUN returns to IDLE next cycle with no further edges; done is not asserted.
  - Phase and position hold their current values.
  - Abort in IDLE is ignored.
  - If abort and the final edge occur in the same cycle, the edge is emitted, done pulses and abort has no further effect.
- cmd_valid while busy is ignored (cmd_ready = 0); a bench holding valid is accepted once IDLE returns.

## Timing
- Reset values: enc_a=0, enc_b=0, position=0, busy=0, done=0, cmd_ready=1, state IDLE.
- Reset asserted mid-command:
  - All outputs return to reset values immediately (asynchronous).
  - The command is discarded.
- Accept at rising edge k with period P and N steps:
  - Edge i (1..N) becomes visible after rising edge k + i·P.
  - busy is high from k+1 until the edge at k+N·P.
  - done and cmd_ready are high after edge k+N·P.
- Back-to-back commands:
  - A command accepted in the done cycle has its first edge exactly P' cycles later, so spacing stays uniform across commands.
- Output frequency: one full quadrature cycle = 4·P clocks; at P=1, A/B each toggle every 2 clocks.
- Zero-step command: done one cycle after accept; cmd_ready stays 1.

## Test plan
- Reset, then forward N=4, P=3: {A,B} = 10,11,01,00 at accept+3,6,9,12; position=4; done pulses once at +12; busy high for cycles +1..+11.
- Reverse N=5, P=1 from phase 00: sequence 01,11,10,00,01 on consecutive clocks; position goes 0→−5 (0xFFFFFFFB).
- Period 0 vs period 1 with N=2: identical edge timing; cmd_period=0 never stalls.
- Abort at accept+7 during N=10, P=2 forward: exactly 3 edges emitted, position=3, done never asserted, cmd_ready=1 one cycle after abort.
- Back-to-back:
  - Forward N=2, P=4, then reverse N=2, P=4 accepted on the done cycle.
  - Edges evenly spaced every 4 clocks; phase reverses from the current state, not from 00.
  - Final position=0.
- Wrap and reset:
  - With POS_W=8, forward 130 steps: position wraps 127→−128.
  - Assert reset_reset_n low mid-RUN: all outputs return to 0 (cmd_ready=1) without waiting for a clock edge.
